mdu_sequencer: RTL and testbench



---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_iter_core.sv | 100 ++++++++++
 rtl/mdu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mdu_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the RV32M multiply/divide sequencer.
//   XLEN / CNT_W      : datapath and iteration-counter widths
//   *_F3              : RV32M funct3 encodings
//   state_e           : sequencer FSM encoding
//   DIV0_Q / INT_MIN  : architecturally defined special results
package mdu_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    localparam logic [2:0] MUL_F3    = 3'b000;
    localparam logic [2:0] MULH_F3   = 3'b001;
    localparam logic [2:0] MULHSU_F3 = 3'b010;
    localparam logic [2:0] MULHU_F3  = 3'b011;
    localparam logic [2:0] DIV_F3    = 3'b100;
    localparam logic [2:0] DIVU_F3   = 3'b101;
    localparam logic [2:0] REM_F3    = 3'b110;
    localparam logic [2:0] REMU_F3   = 3'b111;

    localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: iterative datapath for unsigned magnitudes.
//   Multiply: 64-bit accumulator, shifted multiplicand, multiplier consumed LSB first.
//   Divide  : restoring division in {remainder, quotient} held in the accumulator.
// Ports:
//   clk, rst_i      : clock, synchronous active-high reset
//   load_i          : capture magnitudes and op class, clear iteration counter
//   step_i          : perform one iteration
//   div_i           : op class at load (1 = divide)
//   a_mag_i/b_mag_i : operand magnitudes
//   acc_nxt_o       : accumulator value after the current iteration
//   last_o          : current iteration is the final (XLEN-th) one
//   mplier_done_o   : no multiplier bits remain after the current iteration
module mdu_iter_core
    import mdu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              div_i,
    input  logic [XLEN-1:0]   a_mag_i,
    input  logic [XLEN-1:0]   b_mag_i,
    output logic [2*XLEN-1:0] acc_nxt_o,
    output logic              last_o,
    output logic              mplier_done_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              div_q, div_d;

    logic [XLEN:0]     shifted;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_nxt;

    // For divide, the low half of mcand_q holds the divisor. The partial
    // remainder shifted left can be XLEN+1 bits; when it is >= divisor the
    // true difference is below 2^XLEN, so a XLEN-bit subtract is exact.
    always_comb begin
        shifted = acc_q[2*XLEN-1:XLEN-1];
        rem_ge  = (shifted >= {1'b0, mcand_q[XLEN-1:0]});
        rem_nxt = rem_ge ? (shifted[XLEN-1:0] - mcand_q[XLEN-1:0]) : shifted[XLEN-1:0];
        if (div_q) begin
            acc_nxt_o = {rem_nxt, acc_q[XLEN-2:0], rem_ge};
        end else if (mplier_q[0]) begin
            acc_nxt_o = acc_q + mcand_q;
        end else begin
            acc_nxt_o = acc_q;
        end
    end

    assign last_o        = (cnt_q == CNT_W'(XLEN-1));
    assign mplier_done_o = ~|mplier_q[XLEN-1:1];

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        if (load_i) begin
            div_d    = div_i;
            cnt_d    = '0;
            mplier_d = b_mag_i;
            if (div_i) begin
                acc_d   = {{XLEN{1'b0}}, a_mag_i};
                mcand_d = {{XLEN{1'b0}}, b_mag_i};
            end else begin
                acc_d   = '0;
                mcand_d = {{XLEN{1'b0}}, a_mag_i};
            end
        end else if (step_i) begin
            acc_d    = acc_nxt_o;
            cnt_d    = cnt_q + CNT_W'(1);
            mplier_d = mplier_q >> 1;
            if (!div_q) begin
                mcand_d = mcand_q << 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            div_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: RV32M multiply/divide sequencer for the EX stage.
// Optional build macro: MDU_EARLY_OUT_EN -- multiplies finish as soon as no
// multiplier bits remain (|b| = 0 completes in two cycles).
// Ports:
//   clk, rst_i : clock, synchronous active-high reset
//   start_i    : valid M-extension op in EX
//   funct3_i   : RV32M funct3
//   a_i, b_i   : rs1 / rs2 operands
//   flush_i    : abort the in-flight op
//   busy_alu   : op accepted or in progress (stall request)
//   valid_alu  : one-cycle pulse, result_o final
//   result_o   : result, held until the next completion
//
// state | meaning
// IDLE  | waiting; busy follows start_i & ~flush_i combinationally
// CALC  | one iteration per cycle in mdu_iter_core
// DONE  | result_o valid, valid_alu pulses
module mdu_sequencer
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            busy_alu,
    output logic            valid_alu,
    output logic [XLEN-1:0] result_o
);

`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            neg_q, neg_d;
    logic            sel_q, sel_d;
    logic            div_q, div_d;

    logic            is_div, is_rem, mul_hi, a_signed, b_signed;
    logic            a_neg, b_neg, div0, ovf, spec_hit;
    logic [XLEN-1:0] a_mag, b_mag, spec_res;
    logic            core_load, core_step, core_last, core_mdone;
    logic [2*XLEN-1:0] core_acc, prod_s;
    logic [XLEN-1:0] quo, rem, calc_res;

    always_comb begin
        is_div   = (funct3_i == DIV_F3) || (funct3_i == DIVU_F3) ||
                   (funct3_i == REM_F3) || (funct3_i == REMU_F3);
        is_rem   = (funct3_i == REM_F3) || (funct3_i == REMU_F3);
        mul_hi   = (funct3_i == MULH_F3) || (funct3_i == MULHSU_F3) || (funct3_i == MULHU_F3);
        // MUL's low half is sign-agnostic; treating it as signed keeps |b| small
        // for negative multipliers, which matters for early-out.
        a_signed = (funct3_i == MUL_F3) || (funct3_i == MULH_F3) || (funct3_i == MULHSU_F3) ||
                   (funct3_i == DIV_F3) || (funct3_i == REM_F3);
        b_signed = (funct3_i == MUL_F3) || (funct3_i == MULH_F3) ||
                   (funct3_i == DIV_F3) || (funct3_i == REM_F3);
        a_neg    = a_signed & a_i[XLEN-1];
        b_neg    = b_signed & b_i[XLEN-1];
        a_mag    = a_neg ? -a_i : a_i;
        b_mag    = b_neg ? -b_i : b_i;

        div0     = is_div && (b_i == '0);
        ovf      = is_div && b_signed && (a_i == INT_MIN) && (b_i == '1);
        spec_hit = div0 || ovf || (EARLY_OUT && !is_div && (b_mag == '0));
        if (div0) begin
            spec_res = is_rem ? a_i : DIV0_Q;
        end else if (ovf) begin
            spec_res = is_rem ? '0 : INT_MIN;
        end else begin
            spec_res = '0;
        end
    end

    // Sign fix-up applied to the value the accumulator takes on the final
    // iteration, so result_q is loaded on the same edge that enters DONE.
    always_comb begin
        prod_s = neg_q ? -core_acc : core_acc;
        quo    = core_acc[XLEN-1:0];
        rem    = core_acc[2*XLEN-1:XLEN];
        if (div_q) begin
            if (sel_q) calc_res = neg_q ? -rem : rem;
            else       calc_res = neg_q ? -quo : quo;
        end else begin
            calc_res = sel_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        neg_d     = neg_q;
        sel_d     = sel_q;
        div_d     = div_q;
        core_load = 1'b0;
        core_step = 1'b0;
        busy_alu  = 1'b0;
        valid_alu = 1'b0;
        case (state_q)
            IDLE: begin
                busy_alu = start_i & ~flush_i;
                if (start_i && !flush_i) begin
                    if (spec_hit) begin
                        result_d = spec_res;
                        state_d  = DONE;
                    end else begin
                        core_load = 1'b1;
                        div_d     = is_div;
                        sel_d     = is_div ? is_rem : mul_hi;
                        neg_d     = (is_div && is_rem) ? a_neg : (a_neg ^ b_neg);
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                busy_alu = 1'b1;
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    core_step = 1'b1;
                    if (core_last || (EARLY_OUT && !div_q && core_mdone)) begin
                        result_d = calc_res;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                valid_alu = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q  <= IDLE;
            result_q <= '0;
            neg_q    <= 1'b0;
            sel_q    <= 1'b0;
            div_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            sel_q    <= sel_d;
            div_q    <= div_d;
        end
    end

    assign result_o = result_q;

    mdu_iter_core u_core (
        .clk          (clk),
        .rst_i        (rst_i),
        .load_i       (core_load),
        .step_i       (core_step),
        .div_i        (is_div),
        .a_mag_i      (a_mag),
        .b_mag_i      (b_mag),
        .acc_nxt_o    (core_acc),
        .last_o       (core_last),
        .mplier_done_o(core_mdone)
    );

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: vector table of RV32M ops checked through a result/latency
// scoreboard, plus hand-written flush, reset and flush-in-DONE sequences.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst_i, start_i, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] a_i, b_i;
    logic        busy_alu, valid_alu;
    logic [31:0] result_o;

    mdu_sequencer dut (
        .clk      (clk),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .busy_alu (busy_alu),
        .valid_alu(valid_alu),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;
    localparam int NVEC = 21;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        int          lat;
    } exp_t;

    vec_t        vecs [NVEC];
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_exp = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Cycles from the start_i edge to the valid_alu cycle, inclusive.
    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m;
        int          n;
        if (f3[2]) begin
            if (b == 32'd0) return 2;
            if ((f3 == F_DIV || f3 == F_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
            return 34;
        end
`ifdef MDU_EARLY_OUT_EN
        m = ((f3 == F_MUL || f3 == F_MULH) && b[31]) ? -b : b;
        n = 0;
        while (m != 32'd0) begin
            n++;
            m = m >> 1;
        end
        return 2 + n;
`else
        m = a;
        n = 34;
        return n;
`endif
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input string name);
        exp_t e;
        int   cyc;
        bit   seen;
        bit   busy_ok;
        e.res = exp_res;
        e.lat = exp_lat(f3, a, b);
        sb.push_back(e);
        @(negedge clk);
        funct3_i = f3; a_i = a; b_i = b; start_i = 1'b1;
        #1;
        check({name, "_busy_accept"}, 32'(busy_alu), 32'd1);
        cyc = 1; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (valid_alu) seen = 1'b1;
            else if (!busy_alu) busy_ok = 1'b0;
        end
        start_i = 1'b0;
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_busy_calc"}, 32'(busy_ok), 32'd1);
        e = sb.pop_front();
        check({name, "_latency"}, 32'(cyc), 32'(e.lat));
        check({name, "_result"}, result_o, e.res);
        check({name, "_busy_done"}, 32'(busy_alu), 32'd0);
        @(posedge clk); #1;
        check({name, "_valid_pulse"}, 32'(valid_alu), 32'd0);
        last_exp = e.res;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_valid;
        rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        funct3_i = 3'b000; a_i = 32'd0; b_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   32'(busy_alu),  32'd0);
        check("reset_valid",  32'(valid_alu), 32'd0);
        check("reset_result", result_o,       32'd0);
        @(negedge clk);
        rst_i = 1'b0;

        vecs[0]  = '{F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{F_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3]  = '{F_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{F_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[5]  = '{F_MUL,    32'h1234_5678,  32'd0,         32'd0};
        vecs[6]  = '{F_MUL,    32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'd16};
        vecs[7]  = '{F_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[8]  = '{F_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[9]  = '{F_DIVU,   32'd100,        32'd7,         32'd14};
        vecs[10] = '{F_REMU,   32'd100,        32'd7,         32'd2};
        vecs[11] = '{F_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD};
        vecs[12] = '{F_REM,    32'd7,          32'hFFFF_FFFE, 32'd1};
        vecs[13] = '{F_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vecs[14] = '{F_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[15] = '{F_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[16] = '{F_REMU,   32'd5,          32'd0,         32'd5};
        vecs[17] = '{F_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[18] = '{F_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vecs[19] = '{F_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[20] = '{F_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB};

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Flush in the 10th CALC cycle: abort, no valid, result_o unchanged.
        @(negedge clk);
        funct3_i = F_DIVU; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk); #1;
        check("flush_busy", 32'(busy_alu), 32'd0);
        start_i = 1'b0; flush_i = 1'b0;
        check("flush_valid", 32'(valid_alu), 32'd0);
        check("flush_result", result_o, last_exp);
        saw_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (valid_alu) saw_valid = 1'b1;
        end
        check("flush_no_valid", 32'(saw_valid), 32'd0);
        check("flush_hold", result_o, last_exp);
        run_op(F_DIVU, 32'd9, 32'd3, 32'd3, "divu_after_flush");

        // Reset in the 5th CALC cycle.
        @(negedge clk);
        funct3_i = F_MULHU; a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF; start_i = 1'b1;
        repeat (5) @(negedge clk);
        rst_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy",   32'(busy_alu),  32'd0);
        check("midrst_valid",  32'(valid_alu), 32'd0);
        check("midrst_result", result_o,       32'd0);
        last_exp = 32'd0;
        @(negedge clk);
        rst_i = 1'b0;
        run_op(F_MUL, 32'd5, 32'd3, 32'd15, "mul_after_reset");

        // Flush arriving in DONE must not suppress the completed op.
        @(negedge clk);
        funct3_i = F_DIV; a_i = 32'd5; b_i = 32'd0; start_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b1; start_i = 1'b0;
        #1;
        check("done_flush_valid",  32'(valid_alu), 32'd1);
        check("done_flush_result", result_o,       32'hFFFF_FFFF);
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("done_flush_after", 32'(valid_alu), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
